// File: rtl/dly_load_seq.sv
// dly_load_seq
// Holds a shadow copy of the 19 per-bit delay settings of one byte lane
// (odelay DQ0-7/DQS/DM at addresses 0..9, idelay DQ0-7/DQS at 16..24) and
// replays them into the lane's delay chain on request.
//
// A start pulse scans all 19 entries in ascending address order, one per
// cycle. Each entry is loaded in "all" mode, or in "dirty" mode when it has
// been written since it was last loaded. SET_WAIT quiet cycles follow the
// scan, then a set pulse commits the delays and a done pulse closes the
// sequence.
//
// Ports
//   clk_div      : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   wr_en        : write one shadow entry
//   wr_addr[4:0] : shadow address (0..9, 16..24 valid; others ignored)
//   wr_data[7:0] : delay value (3 LSBs = fine delay)
//   start_all    : pulse, load every entry then set
//   start_dirty  : pulse, load dirty entries only then set
//   dly_data[7:0]: delay value to the lane (registered)
//   dly_addr[4:0]: delay select to the lane (registered)
//   ld_delay     : load strobe to the lane (registered)
//   set          : apply-all-delays strobe (registered)
//   busy         : sequence in progress (registered)
//   done         : one-cycle completion pulse (registered)
module dly_load_seq #(
  parameter logic [7:0]  INIT_DLY = 8'h00,
  parameter int unsigned SET_WAIT = 2      // 1..7
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start_all,
  input  logic       start_dirty,
  output logic [7:0] dly_data,
  output logic [4:0] dly_addr,
  output logic       ld_delay,
  output logic       set,
  output logic       busy,
  output logic       done
);

  localparam int unsigned N_ENT     = 19;
  localparam logic [4:0]  LAST_IDX  = 5'(N_ENT - 1);
  localparam logic [2:0]  WAIT_LAST = 3'(SET_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT,
    S_SET,
    S_DONE
  } state_e;

  // Shadow file, indexed 0..18 (address 16..24 maps to index 10..18).
  logic [7:0]       shadow_q [N_ENT];
  logic [N_ENT-1:0] dirty_q;

  state_e     state_q;
  logic [4:0] idx_q;        // scan position, 0..18
  logic [2:0] wait_q;       // cycles spent in WAIT
  logic       mode_all_q;   // 1: load every entry, 0: dirty entries only
  logic [7:0] dly_data_q;
  logic [4:0] dly_addr_q;
  logic       ld_q;
  logic       set_q;
  logic       busy_q;
  logic       done_q;

  // Write address decode: fold the two valid windows onto the 0..18 index.
  logic       wr_hit;
  logic [4:0] wr_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wr_hit = 1'b0;
    wr_idx = '0;
    if (wr_en) begin
      if (wr_addr <= 5'd9) begin
        wr_hit = 1'b1;
        wr_idx = wr_addr;
      end else if (wr_addr >= 5'd16 && wr_addr <= 5'd24) begin
        wr_hit = 1'b1;
        wr_idx = wr_addr - 5'd6;
      end
    end
  end

  // Address presented to the lane for the entry currently being visited.
  logic [4:0] scan_addr;
  logic       ld_now;

  assign scan_addr = (idx_q < 5'd10) ? idx_q : idx_q + 5'd6;
  assign ld_now    = (state_q == S_SCAN) && (mode_all_q || dirty_q[idx_q]);

  // Shadow file and dirty bits.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow file is reset explicitly; every entry must come
      // out of reset at INIT_DLY and marked dirty so the first dirty
      // sequence programs the whole lane.
      for (int i = 0; i < int'(N_ENT); i++) begin
        shadow_q[i] <= INIT_DLY;
      end
      dirty_q <= '1;
    end else begin
      // NOTE: non-blocking assignments; the load below reads the value
      // before this edge's write, and when both touch the same dirty bit
      // the later write assignment wins, so a racing write stays dirty.
      if (ld_now) begin
        dirty_q[idx_q] <= 1'b0;
      end
      if (wr_hit) begin
        shadow_q[wr_idx] <= wr_data;
        dirty_q[wr_idx]  <= 1'b1;
      end
    end
  end

  // Sequencer with registered lane-side outputs. Each state's outputs
  // appear in the cycle after the edge that executes the state, which is
  // why the done pulse is visible while the state is already back in IDLE.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      mode_all_q <= 1'b0;
      dly_data_q <= '0;
      dly_addr_q <= '0;
      ld_q       <= 1'b0;
      set_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Strobes and lane data are single-cycle unless re-asserted.
      ld_q       <= 1'b0;
      set_q      <= 1'b0;
      done_q     <= 1'b0;
      dly_data_q <= '0;
      dly_addr_q <= '0;

      case (state_q)
        S_IDLE: begin
          // done_q marks the done cycle; a start sampled there is dropped.
          if ((start_all || start_dirty) && !done_q) begin
            state_q    <= S_SCAN;
            idx_q      <= '0;
            mode_all_q <= start_all;
          end
        end

        S_SCAN: begin
          busy_q <= 1'b1;
          ld_q   <= ld_now;
          if (ld_now) begin
            dly_addr_q <= scan_addr;
            dly_data_q <= shadow_q[idx_q];
          end
          if (idx_q == LAST_IDX) begin
            state_q <= S_WAIT;
            wait_q  <= '0;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end

        S_WAIT: begin
          busy_q <= 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_q <= S_SET;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end

        S_SET: begin
          busy_q  <= 1'b1;
          set_q   <= 1'b1;
          state_q <= S_DONE;
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dly_data = dly_data_q;
  assign dly_addr = dly_addr_q;
  assign ld_delay = ld_q;
  assign set      = set_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dly_load_seq.sv
// tb_dly_load_seq
// Scoreboard bench for dly_load_seq. The driver steps a behavioural model
// once per clock edge; the model pushes every lane event (load, set, done)
// it expects, tagged with the edge number, into a queue. A separate
// monitor samples the DUT 1 ns after each rising edge and pops/compares
// whenever the DUT shows an event.
`timescale 1ns/1ps
module tb_dly_load_seq;

  localparam logic [7:0] INIT = 8'hA5;
  localparam int         SW   = 2;

  logic       clk_div     = 1'b0;
  logic       rst_n       = 1'b1;
  logic       wr_en       = 1'b0;
  logic [4:0] wr_addr     = '0;
  logic [7:0] wr_data     = '0;
  logic       start_all   = 1'b0;
  logic       start_dirty = 1'b0;
  logic [7:0] dly_data;
  logic [4:0] dly_addr;
  logic       ld_delay;
  logic       set;
  logic       busy;
  logic       done;

  dly_load_seq #(.INIT_DLY(INIT), .SET_WAIT(SW)) dut (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start_all  (start_all),
    .start_dirty(start_dirty),
    .dly_data   (dly_data),
    .dly_addr   (dly_addr),
    .ld_delay   (ld_delay),
    .set        (set),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_div = ~clk_div;

  // Rising-edge counter: value k means edge k has just occurred.
  int cyc = 0;
  always @(posedge clk_div) cyc <= cyc + 1;

  typedef enum int { EV_LD = 0, EV_SET = 1, EV_DONE = 2 } ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  ld_seen      = 0;

  // ---------------- reference model ----------------
  // Indexed directly by lane address; only valid addresses are touched.
  logic [7:0] m_val   [32];
  bit         m_dirty [32];
  bit         seq_on  = 1'b0;
  int         seq_e0  = 0;   // edge at which the running sequence started
  bit         seq_all = 1'b0;
  int         scan_list [19];

  function automatic bit valid_addr(input logic [4:0] a);
    return (a <= 5'd9) || (a >= 5'd16 && a <= 5'd24);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]   = INIT;
      m_dirty[i] = 1'b1;
    end
    seq_on = 1'b0;
    exp_q.delete();
  endfunction

  // Expected busy level for the cycle following edge c.
  function automatic bit model_busy(input int c);
    return seq_on && (c - seq_e0) >= 1 && (c - seq_e0) <= 20 + SW;
  endfunction

  // Apply the inputs currently driven as they will be sampled at edge e.
  function automatic void model_edge(input int e);
    int k;
    int a;
    k = e - seq_e0;
    if (seq_on && k >= 1 && k <= 19) begin
      a = scan_list[k-1];
      if (seq_all || m_dirty[a]) begin
        exp_q.push_back('{kind: EV_LD, cyc: e, addr: 5'(a), data: m_val[a]});
        m_dirty[a] = 1'b0;
      end
    end
    if (seq_on && k == 20 + SW)
      exp_q.push_back('{kind: EV_SET, cyc: e, addr: 5'd0, data: 8'd0});
    if (seq_on && k == 21 + SW)
      exp_q.push_back('{kind: EV_DONE, cyc: e, addr: 5'd0, data: 8'd0});
    if (wr_en && valid_addr(wr_addr)) begin
      m_val[wr_addr]   = wr_data;
      m_dirty[wr_addr] = 1'b1;
    end
    // Idle again only from the edge after the done cycle.
    if ((start_all || start_dirty) && (!seq_on || k >= 23 + SW)) begin
      seq_on  = 1'b1;
      seq_e0  = e;
      seq_all = start_all;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic match(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL unexpected_event @edge %0d: got kind %0d (addr %0h data %0h), expected none",
               cyc, kind, dly_addr, dly_data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_edge", cyc, e.cyc);
      if (kind == EV_LD) begin
        check("ld_addr", dly_addr, e.addr);
        check("ld_data", dly_data, e.data);
      end
    end
  endtask

  task automatic monitor_sample();
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      tests_run++;
      tests_failed++;
      $display("FAIL missing_event kind %0d: got nothing by edge %0d, expected at edge %0d",
               e.kind, cyc, e.cyc);
    end
    check("ld_set_exclusive", {31'd0, ld_delay & set}, 32'd0);
    check("busy", busy, model_busy(cyc));
    if (ld_delay) begin
      ld_seen++;
      match(EV_LD);
    end else begin
      check("idle_addr", dly_addr, 5'd0);
      check("idle_data", dly_data, 8'd0);
    end
    if (set)  match(EV_SET);
    if (done) match(EV_DONE);
  endtask

  initial begin
    forever begin
      @(posedge clk_div);
      #1;
      if (rst_n) monitor_sample();
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    model_edge(cyc + 1);
    @(negedge clk_div);
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic start(input bit all);
    start_all = all; start_dirty = !all;
    step();
    start_all = 1'b0; start_dirty = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && seq_on && (cyc + 1 - seq_e0) < 23 + SW; i++) step();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string name);
    wr_en = 1'b0; start_all = 1'b0; start_dirty = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check(name, {8'd0, dly_data, dly_addr, ld_delay, set, busy, done}, 32'd0);
    @(negedge clk_div);
    @(negedge clk_div);
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    for (int j = 0; j < 10; j++) scan_list[j] = j;
    for (int j = 0; j < 9; j++)  scan_list[10 + j] = 16 + j;

    #2;
    do_reset("reset_outputs");

    // Power-up: everything dirty, all 19 entries load INIT.
    base = ld_seen;
    start(1'b0);
    wait_idle();
    check("powerup_dirty_loads", ld_seen - base, 19);

    // Two writes, then only those two entries load.
    write(5'd3, 8'h5A);
    write(5'd24, 8'hC1);
    base = ld_seen;
    start(1'b0);
    wait_idle();
    check("two_dirty_loads", ld_seen - base, 2);

    // Nothing dirty: empty scan, set and done still occur.
    base = ld_seen;
    start(1'b0);
    wait_idle();
    check("clean_scan_loads", ld_seen - base, 0);

    // Writes racing an "all" scan: addr 5 before its visit, addr 1 after.
    base = ld_seen;
    start(1'b1);
    step();
    step();
    write(5'd5, 8'h11);
    step();
    write(5'd1, 8'h22);
    wait_idle();
    check("all_scan_loads", ld_seen - base, 19);
    base = ld_seen;
    start(1'b0);
    wait_idle();
    check("late_write_dirty_loads", ld_seen - base, 1);

    // Invalid write, start while busy, start in the done cycle.
    write(5'd12, 8'hFF);
    base = ld_seen;
    start(1'b0);
    repeat (5) step();
    start(1'b1);
    while (cyc < seq_e0 + 21 + SW) step();
    start(1'b1);
    repeat (30) step();
    check("ignored_starts_loads", ld_seen - base, 0);
    base = ld_seen;
    start(1'b1);
    wait_idle();
    check("shadow_intact_loads", ld_seen - base, 19);

    // Reset in SCAN cycle 10: abort, no set, all entries dirty again.
    start(1'b0);
    repeat (10) step();
    do_reset("reset_mid_scan");
    base = ld_seen;
    start(1'b0);
    wait_idle();
    check("post_reset_loads", ld_seen - base, 19);

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      wr_en       = ($urandom_range(0, 99) < 35);
      wr_addr     = 5'($urandom);
      wr_data     = 8'($urandom);
      start_all   = ($urandom_range(0, 19) == 0);
      start_dirty = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) do_reset("random_reset");
      else step();
    end
    wr_en = 1'b0; start_all = 1'b0; start_dirty = 1'b0;
    wait_idle();
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
